// File: rtl/pulse_handshake_tx.sv
// Source-side initiator of a 4-phase req/ack event crossing: queues event pulses in a
// saturating counter and dispatches one level-req handshake per queued event.
module pulse_handshake_tx #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 1024,
    parameter int TMO_W   = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulseIn,
    input  logic             ackSync,
    input  logic             clrErr,
    output logic             req,
    output logic             done,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow,
    output logic             timeoutErr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FULL_VAL = '1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t           state;
    logic [TMO_W-1:0] tmoCnt;
    logic             full;
    logic             dispatch;
    logic             inc;
    logic             tmoHit;
    logic             ovfSet;
    logic             tmoSet;

    assign full     = (pending == FULL_VAL);
    assign dispatch = (state == IDLE) && (pending != '0);
    // A pulse arriving while full still fits if a dispatch frees a slot on the same edge.
    assign inc      = pulseIn && (!full || dispatch);
    assign ovfSet   = pulseIn && full && !dispatch;
    assign tmoHit   = (TIMEOUT != 0) && (tmoCnt == TMO_LAST);
    assign tmoSet   = tmoHit && (((state == WAIT_HI) && !ackSync) ||
                                 ((state == WAIT_LO) && ackSync));
    assign busy     = (state != IDLE) || (pending != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req        <= 1'b0;
            done       <= 1'b0;
            pending    <= '0;
            overflow   <= 1'b0;
            timeoutErr <= 1'b0;
            tmoCnt     <= '0;
        end else begin
            done <= 1'b0;

            if (inc && !dispatch) begin
                pending <= pending + CNT_W'(1);
            end else if (!inc && dispatch) begin
                pending <= pending - CNT_W'(1);
            end

            // A new error event outranks a clear on the same edge.
            overflow   <= ovfSet || (overflow && !clrErr);
            timeoutErr <= tmoSet || (timeoutErr && !clrErr);

            case (state)
                IDLE: begin
                    tmoCnt <= '0;
                    req    <= 1'b0;
                    if (dispatch) begin
                        state <= WAIT_HI;
                        req   <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (ackSync) begin
                        state  <= WAIT_LO;
                        req    <= 1'b0;
                        tmoCnt <= '0;
                    end else if (tmoHit) begin
                        state  <= IDLE;
                        req    <= 1'b0;
                        tmoCnt <= '0;
                    end else if (TIMEOUT != 0) begin
                        tmoCnt <= tmoCnt + TMO_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (!ackSync) begin
                        state  <= IDLE;
                        done   <= 1'b1;
                        tmoCnt <= '0;
                    end else if (tmoHit) begin
                        state  <= IDLE;
                        tmoCnt <= '0;
                    end else if (TIMEOUT != 0) begin
                        tmoCnt <= tmoCnt + TMO_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    req    <= 1'b0;
                    tmoCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Directed bench for pulse_handshake_tx: a default-sized instance for the basic flow and a
// small one (CNT_W=2, TIMEOUT=16) for overflow, timeout and edge cases.
module tb_pulse_handshake_tx;

    logic       clk = 1'b0;
    logic       rst0_n, pulse0, ack0, clr0;
    logic       req0, done0, busy0, ovf0, tmo0;
    logic [3:0] pend0;
    logic       rst1_n, pulse1, ack1, clr1;
    logic       req1, done1, busy1, ovf1, tmo1;
    logic [1:0] pend1;

    int errors = 0;
    int checks = 0;

    // far-side ack model controls and event monitors
    logic ackEn0 = 1'b0, ackEn1 = 1'b0;
    int   ackDly0 = 3, ackDly1 = 2;
    int   doneCnt0 = 0, doneCnt1 = 0, rise0 = 0, rise1 = 0, maxPend0 = 0;
    logic reqPrev0 = 1'b0, reqPrev1 = 1'b0;

    pulse_handshake_tx #(.CNT_W(4), .TIMEOUT(1024), .TMO_W(11)) dut0 (
        .clk(clk), .rst_n(rst0_n), .pulseIn(pulse0), .ackSync(ack0), .clrErr(clr0),
        .req(req0), .done(done0), .pending(pend0), .busy(busy0),
        .overflow(ovf0), .timeoutErr(tmo0)
    );

    pulse_handshake_tx #(.CNT_W(2), .TIMEOUT(16), .TMO_W(5)) dut1 (
        .clk(clk), .rst_n(rst1_n), .pulseIn(pulse1), .ackSync(ack1), .clrErr(clr1),
        .req(req1), .done(done1), .pending(pend1), .busy(busy1),
        .overflow(ovf1), .timeoutErr(tmo1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ack responders: raise ack ackDly cycles after req is seen high, drop it ackDly cycles after req falls.
    initial begin : ack_model0
        int cnt;
        cnt  = 0;
        ack0 = 1'b0;
        forever begin
            tick();
            if (!ackEn0) begin
                ack0 = 1'b0;
                cnt  = 0;
            end else if (req0 != ack0) begin
                cnt++;
                if (cnt >= ackDly0) begin
                    ack0 = req0;
                    cnt  = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : ack_model1
        int cnt;
        cnt  = 0;
        ack1 = 1'b0;
        forever begin
            tick();
            if (!ackEn1) begin
                ack1 = 1'b0;
                cnt  = 0;
            end else if (req1 != ack1) begin
                cnt++;
                if (cnt >= ackDly1) begin
                    ack1 = req1;
                    cnt  = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (done0) doneCnt0++;
        if (done1) doneCnt1++;
        if (req0 && !reqPrev0) rise0++;
        if (req1 && !reqPrev1) rise1++;
        reqPrev0 = req0;
        reqPrev1 = req1;
        if (int'(pend0) > maxPend0) maxPend0 = int'(pend0);
    end

    task automatic wait_done0(input int target, input int budget);
        for (int i = 0; i < budget && doneCnt0 < target; i++) tick();
    endtask

    task automatic wait_done1(input int target, input int budget);
        for (int i = 0; i < budget && doneCnt1 < target; i++) tick();
    endtask

    initial begin
        rst0_n = 1'b0; pulse0 = 1'b0; clr0 = 1'b0;
        rst1_n = 1'b0; pulse1 = 1'b0; clr1 = 1'b0;

        // reset held for 3 cycles
        repeat (3) tick();
        check("rst_req0", 32'(req0), 32'd0);
        check("rst_pend0", 32'(pend0), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_ovf0", 32'(ovf0), 32'd0);
        check("rst_tmo0", 32'(tmo0), 32'd0);
        check("rst_req1", 32'(req1), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        tick();

        // single event: pending at k+1, req at k+2, one done after the ack falls
        ackEn0 = 1'b1; ackDly0 = 3;
        doneCnt0 = 0; rise0 = 0;
        pulse0 = 1'b1;
        tick();
        pulse0 = 1'b0;
        check("single_pend_k1", 32'(pend0), 32'd1);
        check("single_req_k1", 32'(req0), 32'd0);
        check("single_busy_k1", 32'(busy0), 32'd1);
        tick();
        check("single_req_k2", 32'(req0), 32'd1);
        check("single_pend_k2", 32'(pend0), 32'd0);
        wait_done0(1, 60);
        repeat (3) tick();
        check("single_done_cnt", 32'(doneCnt0), 32'd1);
        check("single_rise_cnt", 32'(rise0), 32'd1);
        check("single_pend_end", 32'(pend0), 32'd0);
        check("single_busy_end", 32'(busy0), 32'd0);

        // burst of 5 with a slow far side
        ackDly0 = 4;
        doneCnt0 = 0; rise0 = 0; maxPend0 = 0;
        pulse0 = 1'b1;
        repeat (5) tick();
        pulse0 = 1'b0;
        wait_done0(5, 300);
        repeat (3) tick();
        check("burst_peak", 32'(maxPend0), 32'd4);
        check("burst_rise_cnt", 32'(rise0), 32'd5);
        check("burst_done_cnt", 32'(doneCnt0), 32'd5);
        check("burst_ovf", 32'(ovf0), 32'd0);
        check("burst_busy_end", 32'(busy0), 32'd0);

        // overflow on the small instance: 6 pulses with ack stuck low
        ackEn1 = 1'b0;
        doneCnt1 = 0; rise1 = 0;
        pulse1 = 1'b1;
        repeat (4) tick();
        check("ovf_pend_full", 32'(pend1), 32'd3);
        check("ovf_not_yet", 32'(ovf1), 32'd0);
        repeat (2) tick();
        pulse1 = 1'b0;
        check("ovf_pend_sat", 32'(pend1), 32'd3);
        check("ovf_set", 32'(ovf1), 32'd1);
        ackEn1 = 1'b1; ackDly1 = 2;
        wait_done1(4, 200);
        repeat (3) tick();
        check("ovf_done_cnt", 32'(doneCnt1), 32'd4);
        check("ovf_rise_cnt", 32'(rise1), 32'd4);
        check("ovf_sticky", 32'(ovf1), 32'd1);
        check("ovf_no_tmo", 32'(tmo1), 32'd0);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        check("ovf_cleared", 32'(ovf1), 32'd0);

        // timeout: ack never rises, second queued event then dispatches
        ackEn1 = 1'b0;
        doneCnt1 = 0;
        pulse1 = 1'b1;
        repeat (2) tick();
        pulse1 = 1'b0;
        check("tmo_req_start", 32'(req1), 32'd1);
        check("tmo_pend_q", 32'(pend1), 32'd1);
        repeat (15) tick();
        check("tmo_req_15", 32'(req1), 32'd1);
        check("tmo_err_15", 32'(tmo1), 32'd0);
        tick();
        check("tmo_req_16", 32'(req1), 32'd0);
        check("tmo_err_16", 32'(tmo1), 32'd1);
        check("tmo_pend_16", 32'(pend1), 32'd1);
        ackEn1 = 1'b1;
        tick();
        check("tmo_next_req", 32'(req1), 32'd1);
        check("tmo_next_pend", 32'(pend1), 32'd0);
        wait_done1(1, 60);
        repeat (2) tick();
        check("tmo_done_cnt", 32'(doneCnt1), 32'd1);

        // pulse on the dispatch edge while full: no overflow, pending unchanged
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        ackEn1 = 1'b0;
        pulse1 = 1'b1;
        repeat (4) tick();
        pulse1 = 1'b0;
        check("edge_pend_full", 32'(pend1), 32'd3);
        repeat (14) tick();
        check("edge_tmo_idle", 32'(req1), 32'd0);
        check("edge_tmo_err", 32'(tmo1), 32'd1);
        pulse1 = 1'b1;
        tick();
        pulse1 = 1'b0;
        check("edge_disp_req", 32'(req1), 32'd1);
        check("edge_disp_pend", 32'(pend1), 32'd3);
        check("edge_disp_ovf", 32'(ovf1), 32'd0);

        // clrErr together with a new overflow: set wins; timeoutErr clears
        pulse1 = 1'b1; clr1 = 1'b1;
        tick();
        pulse1 = 1'b0; clr1 = 1'b0;
        check("clr_vs_set_ovf", 32'(ovf1), 32'd1);
        check("clr_tmo", 32'(tmo1), 32'd0);
        check("clr_vs_set_pend", 32'(pend1), 32'd3);

        // reset while in WAIT_HI drops req at the next edge
        check("mid_rst_req_pre", 32'(req1), 32'd1);
        rst1_n = 1'b0;
        tick();
        check("mid_rst_req", 32'(req1), 32'd0);
        check("mid_rst_pend", 32'(pend1), 32'd0);
        check("mid_rst_ovf", 32'(ovf1), 32'd0);
        check("mid_rst_busy", 32'(busy1), 32'd0);
        rst1_n = 1'b1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
